rf_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two requesters: requester 0 (ALU writeback) and requester 1 (memory-load writeback).
- The register file is built from REG32 banks plus the 5x32 write-address decoder.
- Arbitration is round-robin over a valid/ready handshake, with one registered output stage.
- Also sequences a full-file clear, one register per cycle, on command.

---
 rtl/rf_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with one registered
// output stage and a sequenced full-file clear.
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit R0_PROTECT = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_DATA,
    output logic                  REQ1_READY,
    input  logic                  STALL,
    input  logic                  CLR_REQ,
    output logic                  RF_WE,
    output logic [ADDR_WIDTH-1:0] RF_WADDR,
    output logic [DATA_WIDTH-1:0] RF_WDATA,
    output logic                  GRANT_ID,
    output logic                  BUSY,
    output logic                  CLR_DONE
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    prio_q, prio_d;
    logic                    rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    grant_q, grant_d;
    logic                    clr_done_q, clr_done_d;
    logic                    busy_q, busy_d;

    logic                    stage_free_s;
    logic                    stage_consumed_s;
    logic                    accept_ok_s;
    logic                    req0_ready_s;
    logic                    req1_ready_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;

    assign stage_free_s     = ~rf_we_q | ~STALL;
    assign stage_consumed_s = rf_we_q & ~STALL;
    // READY is forced low while RESET is asserted so nothing handshakes during reset.
    assign accept_ok_s      = RESET & (state_q == ST_RUN) & ~pend_q & stage_free_s;
    assign req0_ready_s     = accept_ok_s & REQ0_VALID & (~REQ1_VALID | (prio_q == 1'b0));
    assign req1_ready_s     = accept_ok_s & REQ1_VALID & (~REQ0_VALID | (prio_q == 1'b1));
    assign sel_addr_s       = req1_ready_s ? REQ1_ADDR : REQ0_ADDR;
    assign sel_data_s       = req1_ready_s ? REQ1_DATA : REQ0_DATA;

    // State register and all sequential datapath state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_RUN;
            pend_q     <= 1'b0;
            cnt_q      <= ZERO_ADDR;
            prio_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= ZERO_ADDR;
            rf_wdata_q <= ZERO_DATA;
            grant_q    <= 1'b0;
            clr_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_q    <= grant_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state: clear request capture, entry into CLEAR once the stage drains, clear counter.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (pend_q) begin
                    if (stage_free_s) begin
                        state_d = ST_CLEAR;
                        pend_d  = 1'b0;
                        cnt_d   = ZERO_ADDR;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (CLR_REQ) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                // cnt_q tracks the address held in the stage; advance only when it is consumed.
                if (stage_consumed_s) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + ONE_ADDR;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
                cnt_d   = ZERO_ADDR;
            end
        endcase
    end

    // Output stage load: accepted request in RUN, zero writes in CLEAR, hold on stall.
    always_comb begin
        prio_d     = prio_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_d    = grant_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (req0_ready_s | req1_ready_s) begin
                    prio_d     = ~req1_ready_s;
                    rf_waddr_d = sel_addr_s;
                    rf_wdata_d = sel_data_s;
                    grant_d    = req1_ready_s;
                    rf_we_d    = ~(R0_PROTECT && (sel_addr_s == ZERO_ADDR));
                end else if (stage_consumed_s) begin
                    rf_we_d = 1'b0;
                end else begin
                    rf_we_d = rf_we_q;
                end
            end
            ST_CLEAR: begin
                if (stage_free_s) begin
                    if (stage_consumed_s && (cnt_q == LAST_ADDR)) begin
                        rf_we_d    = 1'b0;
                        clr_done_d = 1'b1;
                    end else begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = cnt_d;
                        rf_wdata_d = ZERO_DATA;
                        grant_d    = 1'b0;
                    end
                end else begin
                    rf_we_d = rf_we_q;
                end
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
        busy_d = pend_d | (state_d == ST_CLEAR);
    end

    assign REQ0_READY = req0_ready_s;
    assign REQ1_READY = req1_ready_s;
    assign RF_WE      = rf_we_q;
    assign RF_WADDR   = rf_waddr_q;
    assign RF_WDATA   = rf_wdata_q;
    assign GRANT_ID   = grant_q;
    assign BUSY       = busy_q;
    assign CLR_DONE   = clr_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed steps plus random traffic,
// all compared against a transaction-level reference model.
module tb_rf_write_arbiter;

    logic        CLK;
    logic        RESET;
    logic        REQ0_VALID, REQ1_VALID;
    logic [4:0]  REQ0_ADDR, REQ1_ADDR;
    logic [31:0] REQ0_DATA, REQ1_DATA;
    logic        REQ0_READY, REQ1_READY;
    logic        STALL, CLR_REQ;
    logic        RF_WE;
    logic [4:0]  RF_WADDR;
    logic [31:0] RF_WDATA;
    logic        GRANT_ID, BUSY, CLR_DONE;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int wlog[$];

    // Reference model state
    logic        m_prio, m_we, m_gid, m_pend, m_clearing, m_done, m_busy;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          clrq[$];

    rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .R0_PROTECT(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .STALL(STALL), .CLR_REQ(CLR_REQ),
        .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .GRANT_ID(GRANT_ID),
        .BUSY(BUSY), .CLR_DONE(CLR_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check READY before the edge, advance the model at the edge, check registered outputs after.
    task automatic cycle();
        logic free, cons, rok, e_r0, e_r1, i;
        logic [4:0] a;
        #2;
        free = !m_we || !STALL;
        cons = m_we && !STALL;
        rok  = RESET && !m_clearing && !m_pend && free;
        e_r0 = rok && REQ0_VALID && (!REQ1_VALID || m_prio == 1'b0);
        e_r1 = rok && REQ1_VALID && (!REQ0_VALID || m_prio == 1'b1);
        chk("req0_ready", {31'd0, REQ0_READY}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, REQ1_READY}, {31'd0, e_r1});
        if (RF_WE === 1'b1 && STALL == 1'b0) wlog.push_back(int'(RF_WADDR));
        @(posedge CLK);
        m_done = 1'b0;
        if (!RESET) begin
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_gid = 1'b0;
            m_prio = 1'b0; m_pend = 1'b0; m_clearing = 1'b0;
            clrq.delete();
        end else if (m_clearing) begin
            if (free) begin
                if (cons && clrq.size() == 0) begin
                    m_we = 1'b0; m_done = 1'b1; m_clearing = 1'b0;
                end else if (clrq.size() != 0) begin
                    m_we = 1'b1; m_addr = 5'(clrq.pop_front()); m_data = 32'd0; m_gid = 1'b0;
                end
            end
        end else begin
            if (e_r0 || e_r1) begin
                i = e_r1;
                a = i ? REQ1_ADDR : REQ0_ADDR;
                m_addr = a;
                m_data = i ? REQ1_DATA : REQ0_DATA;
                m_gid  = i;
                m_prio = !i;
                m_we   = (a != 5'd0);
            end else if (cons) begin
                m_we = 1'b0;
            end
            if (m_pend && free) begin
                m_clearing = 1'b1; m_pend = 1'b0;
                for (int k = 0; k < 32; k++) clrq.push_back(k);
            end else if (!m_pend && CLR_REQ) begin
                m_pend = 1'b1;
            end
        end
        m_busy = m_pend || m_clearing;
        #1;
        chk("rf_we",    {31'd0, RF_WE},    {31'd0, m_we});
        chk("rf_waddr", {27'd0, RF_WADDR}, {27'd0, m_addr});
        chk("rf_wdata", RF_WDATA,          m_data);
        chk("grant_id", {31'd0, GRANT_ID}, {31'd0, m_gid});
        chk("busy",     {31'd0, BUSY},     {31'd0, m_busy});
        chk("clr_done", {31'd0, CLR_DONE}, {31'd0, m_done});
        if (CLR_DONE === 1'b1) done_cnt++;
    endtask

    initial begin
        m_prio = 1'b0; m_we = 1'b0; m_gid = 1'b0; m_pend = 1'b0;
        m_clearing = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        m_addr = 5'd0; m_data = 32'd0;
        RESET = 1'b0; STALL = 1'b0; CLR_REQ = 1'b0;
        REQ0_VALID = 1'b1; REQ0_ADDR = 5'd3; REQ0_DATA = 32'hAAAA0000;
        REQ1_VALID = 1'b1; REQ1_ADDR = 5'd7; REQ1_DATA = 32'h5555FFFF;

        // Reset with both requesters valid
        cycle(); cycle();
        chk("reset_we", {31'd0, RF_WE}, 32'd0);
        chk("reset_waddr", {27'd0, RF_WADDR}, 32'd0);
        RESET = 1'b1;

        // Contention: grants alternate starting with requester 0
        for (int k = 0; k < 8; k++) cycle();
        REQ0_VALID = 1'b0;

        // Stall holds the stage and blocks acceptance
        REQ1_ADDR = 5'd9; REQ1_DATA = 32'h12;
        cycle();
        chk("stall_accept_addr", {27'd0, RF_WADDR}, 32'd9);
        REQ1_VALID = 1'b0;
        STALL = 1'b1; REQ0_VALID = 1'b1; REQ0_ADDR = 5'd6; REQ0_DATA = 32'h66;
        for (int k = 0; k < 3; k++) cycle();
        chk("stall_hold_data", RF_WDATA, 32'h12);
        STALL = 1'b0;
        cycle();
        chk("stall_release_addr", {27'd0, RF_WADDR}, 32'd6);

        // R0 protect
        REQ0_ADDR = 5'd0; REQ0_DATA = 32'hFFFFFFFF;
        cycle();
        chk("r0_protect_we", {31'd0, RF_WE}, 32'd0);
        REQ0_ADDR = 5'd1; REQ0_DATA = 32'd5;
        cycle();
        chk("r0_next_we", {31'd0, RF_WE}, 32'd1);
        REQ0_VALID = 1'b0;
        cycle(); cycle();

        // Clear issued alongside a handshake, with a stall inserted mid-clear
        wlog.delete(); done_cnt = 0;
        REQ0_VALID = 1'b1; REQ0_ADDR = 5'd4; REQ0_DATA = 32'h44; CLR_REQ = 1'b1;
        cycle();
        CLR_REQ = 1'b0; REQ1_VALID = 1'b1;
        for (int k = 0; k < 100 && done_cnt == 0; k++) begin
            STALL = (k >= 12 && k < 15);
            cycle();
        end
        STALL = 1'b0;
        chk("clr_done_seen", done_cnt, 32'd1);
        chk("clr_log_size", wlog.size(), 32'd33);
        if (wlog.size() == 33) begin
            chk("clr_log_first", wlog[0], 32'd4);
            for (int k = 0; k < 32; k++) chk("clr_log_addr", wlog[k + 1], k);
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        cycle();
        chk("clr_busy_after", {31'd0, BUSY}, 32'd0);

        // Reset in the middle of a clear
        done_cnt = 0;
        CLR_REQ = 1'b1;
        cycle();
        CLR_REQ = 1'b0;
        for (int k = 0; k < 80; k++) begin
            cycle();
            if (m_clearing && m_we && m_addr == 5'd12) break;
        end
        chk("mid_clear_addr", {27'd0, RF_WADDR}, 32'd12);
        RESET = 1'b0;
        cycle();
        RESET = 1'b1; REQ1_VALID = 1'b1; REQ1_ADDR = 5'd2; REQ1_DATA = 32'h22;
        for (int k = 0; k < 40; k++) cycle();
        chk("mid_clear_no_done", done_cnt, 32'd0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            RESET      = ($urandom_range(0, 199) != 0);
            REQ0_VALID = $urandom_range(0, 1);
            REQ1_VALID = $urandom_range(0, 1);
            REQ0_ADDR  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            REQ1_ADDR  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            REQ0_DATA  = $urandom;
            REQ1_DATA  = $urandom;
            STALL      = ($urandom_range(0, 3) == 0);
            CLR_REQ    = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
